// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared defaults and stage record for the elastic pipeline.
package pipeline_pkg;
   localparam int WIDTH_DEF = 32;
   localparam int DEPTH_DEF = 5;
   localparam int CNT_W_DEF = 32;
   typedef struct packed {
      logic                 valid;
      logic [WIDTH_DEF-1:0] data;
   } stage_t;
endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one valid+data register; clear squashes valid, load captures input.
module pipe_stage #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             clear,
   input  logic             vin,
   input  logic [WIDTH-1:0] din,
   output logic             v,
   output logic [WIDTH-1:0] d
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         v <= 1'b0;
         d <= '0;
      end else if (clear) v <= 1'b0;
      else if (load) begin
         v <= vin;
         d <= din;
      end
endmodule

// File: rtl/pipe_elastic.sv
// pipe_elastic: DEPTH-stage elastic pipeline with bubble collapse, flush and counters.
module pipe_elastic import pipeline_pkg::*; #(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [WIDTH-1:0]           out_data,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] occupancy,
   output logic [CNT_W-1:0]           cycle_cnt,
   output logic [CNT_W-1:0]           retire_cnt
);
   localparam int OW = $clog2(DEPTH+1);
   logic [DEPTH-1:0] v, adv, vin;
   logic [WIDTH-1:0] d [DEPTH];
   logic [WIDTH-1:0] din [DEPTH];
   // a stage loads when it is empty or its occupant moves on this cycle
   always_comb begin
      adv[DEPTH-1] = out_ready || !v[DEPTH-1];
      for (int i = DEPTH - 2; i >= 0; i--) adv[i] = !v[i] || adv[i+1];
      vin[0] = in_valid;
      din[0] = in_data;
      for (int i = 1; i < DEPTH; i++) begin
         vin[i] = v[i-1];
         din[i] = d[i-1];
      end
      occupancy = '0;
      for (int i = 0; i < DEPTH; i++) occupancy = occupancy + OW'(v[i]);
   end
   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      pipe_stage #(.WIDTH(WIDTH)) u_stage (
         .clk  (clk),
         .rst_n(rst_n),
         .load (adv[g]),
         .clear(flush),
         .vin  (vin[g]),
         .din  (din[g]),
         .v    (v[g]),
         .d    (d[g])
      );
   end
   assign in_ready  = adv[0] && !flush;
   assign out_valid = v[DEPTH-1] && !flush;
   assign out_data  = d[DEPTH-1];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cycle_cnt  <= '0;
         retire_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + CNT_W'(1);
         if (out_valid && out_ready) retire_cnt <= retire_cnt + CNT_W'(1);
      end
endmodule
